vga_timing: RTL and testbench

- Generates VGA raster timing for the 80x60-tile (8x8-pixel) framebuffer display path.
- Sits directly upstream of the tile-to-pixel stage and drives it with vga_x, vga_y and vga_blank.
- vga_x and vga_y are issued undelayed so they can form the framebuffer read address.
- vga_blank, vga_hs and vga_vs are delayed by PIPE_DLY cycles to line up with the registered framebuffer read data.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_ctrl_delay.sv | 33 +++
 rtl/vga_timing.sv | 124 ++++++++++++
 tb/tb_vga_timing.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA display path.
//   - 640x480@60 raster timing (pixels / lines)
//   - Tile geometry of the 80x60-tile, 8x8-pixel framebuffer
//   - vga_ctrl_t: {blank, hs, vs} control bundle carried alongside pixel data
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned TILE_W  = 8;
  localparam int unsigned TILES_X = 80;
  localparam int unsigned TILES_Y = 60;

  // blank uses DAC blank_n sense (1 = visible); hs/vs are active low.
  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
  } vga_ctrl_t;

  localparam vga_ctrl_t CTRL_RESET = '{blank: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_ctrl_delay.sv
// N-stage, enable-gated shift register for the {blank, hs, vs} bundle.
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset; every stage -> CTRL_RESET
//   en       in   advance enable; all stages hold when 0
//   d        in   control bundle entering the first stage
//   q        out  control bundle from the last stage
module vga_ctrl_delay
  import vga_pkg::*;
#(
  parameter int unsigned N = 1
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      en,
  input  vga_ctrl_t d,
  output vga_ctrl_t q
);

  vga_ctrl_t stg [N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N; i++) stg[i] <= CTRL_RESET;
    end else if (en) begin
      stg[0] <= d;
      for (int unsigned i = 1; i < N; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[N-1];

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator feeding the tile-to-pixel stage.
// Ports:
//   clk          in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   pix_en       in   counter advance enable; all state holds when 0
//   vga_x        out  current pixel column (0 outside the active area), undelayed
//   vga_y        out  current pixel row (0 outside the active area), undelayed
//   vga_blank    out  1 = visible pixel, delayed PIPE_DLY enabled cycles
//   vga_hs       out  horizontal sync (active low), delayed PIPE_DLY enabled cycles
//   vga_vs       out  vertical sync (active low), delayed PIPE_DLY enabled cycles
//   frame_start  out  pulse while counters read (0,0), undelayed
//   line_start   out  pulse while counters read (0,line<V_ACTIVE), undelayed
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] vga_x,
  output logic [8:0] vga_y,
  output logic       vga_blank,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       frame_start,
  output logic       line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_timing: timing parameters must be non-zero");
  end
  if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_dly
    $error("vga_timing: PIPE_DLY must be in 1..4");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || V_ACTIVE > 512) begin : g_bad_range
    $error("vga_timing: timing does not fit the counter/output widths");
  end

  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic       act_h, act_v;
  logic       origin_q, line_q;
  vga_ctrl_t  ctrl_raw, ctrl_dly;

  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
  end

  // origin_q/line_q are the pulse decodes registered from the next counter
  // value, so they line up with the counters with no added latency. Their
  // reset value matches the (0,0) reset position, which lets the first
  // enabled cycle after release report frame_start and line_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      origin_q <= 1'b1;
      line_q   <= 1'b1;
    end else if (pix_en) begin
      h_cnt    <= h_nxt;
      v_cnt    <= v_nxt;
      origin_q <= (h_nxt == '0) && (v_nxt == '0);
      line_q   <= (h_nxt == '0) && (v_nxt < V_ACT);
    end
  end

  always_comb begin
    act_h          = h_cnt < H_ACT;
    act_v          = v_cnt < V_ACT;
    ctrl_raw.blank = act_h & act_v;
    ctrl_raw.hs    = !((h_cnt >= H_SYNC_ON) && (h_cnt < H_SYNC_OFF));
    ctrl_raw.vs    = !((v_cnt >= V_SYNC_ON) && (v_cnt < V_SYNC_OFF));
  end

  assign vga_x = act_h ? h_cnt : '0;
  assign vga_y = act_v ? v_cnt[8:0] : '0;

  // Gating with reset_n forces the pulses inactive as soon as reset asserts,
  // even though the registered decodes sit at their (0,0) reset value.
  assign frame_start = reset_n & pix_en & origin_q;
  assign line_start  = reset_n & pix_en & line_q;

  vga_ctrl_delay #(
    .N(PIPE_DLY)
  ) u_ctrl_delay (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (pix_en),
    .d      (ctrl_raw),
    .q      (ctrl_dly)
  );

  assign vga_blank = ctrl_dly.blank;
  assign vga_hs    = ctrl_dly.hs;
  assign vga_vs    = ctrl_dly.vs;

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;

  // Scaled-down raster so several frames fit in a short run.
  localparam int unsigned HA  = 40;
  localparam int unsigned HF  = 4;
  localparam int unsigned HSW = 6;
  localparam int unsigned HB  = 4;
  localparam int unsigned VA  = 12;
  localparam int unsigned VF  = 2;
  localparam int unsigned VSW = 2;
  localparam int unsigned VB  = 3;
  localparam int unsigned HT  = HA + HF + HSW + HB;
  localparam int unsigned VT  = VA + VF + VSW + VB;

  logic clk = 1'b0;
  logic reset_n;
  logic pix_en;

  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic blank0, hs0, vs0, fs0, ls0;
  logic blank1, hs1, vs1, fs1, ls1;

  always #5 clk = ~clk;

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .PIPE_DLY(1)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .vga_x(x0), .vga_y(y0), .vga_blank(blank0), .vga_hs(hs0), .vga_vs(vs0),
    .frame_start(fs0), .line_start(ls0)
  );

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .PIPE_DLY(3)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .vga_x(x1), .vga_y(y1), .vga_blank(blank1), .vga_hs(hs1), .vga_vs(vs1),
    .frame_start(fs1), .line_start(ls1)
  );

  int checks = 0;
  int errors = 0;

  // Reference raster position and per-DUT scoreboards of {blank,hs,vs}.
  int mh, mv;
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  // Event trackers for dut0, counted in enabled cycles.
  int en_cyc, last_fs, last_ls, ls_cnt, hs_fall, vs_fall;
  logic prev_hs, prev_vs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] raw_ctrl(input int h, input int v);
    logic b, hs, vs;
    b  = (h < HA) && (v < VA);
    hs = !((h >= HA + HF) && (h < HA + HF + HSW));
    vs = !((v >= VA + VF) && (v < VA + VF + VSW));
    return {b, hs, vs};
  endfunction

  task automatic model_reset();
    mh = 0;
    mv = 0;
    q0.delete();
    q1.delete();
    q0.push_back(3'b011);
    repeat (3) q1.push_back(3'b011);
    en_cyc  = 0;
    last_fs = -1;
    last_ls = -1;
    ls_cnt  = 0;
    hs_fall = -1;
    vs_fall = -1;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
  endtask

  task automatic advance_model();
    q0.push_back(raw_ctrl(mh, mv));
    void'(q0.pop_front());
    q1.push_back(raw_ctrl(mh, mv));
    void'(q1.pop_front());
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  task automatic check_outputs();
    logic [2:0] e0, e1;
    int ex, ey;
    logic efs, els;
    e0  = q0[0];
    e1  = q1[0];
    ex  = (mh < HA) ? mh : 0;
    ey  = (mv < VA) ? mv : 0;
    efs = pix_en && reset_n && (mh == 0) && (mv == 0);
    els = pix_en && reset_n && (mh == 0) && (mv < VA);
    chk("x0", 32'(x0), ex);
    chk("y0", 32'(y0), ey);
    chk("blank0", 32'(blank0), 32'(e0[2]));
    chk("hs0", 32'(hs0), 32'(e0[1]));
    chk("vs0", 32'(vs0), 32'(e0[0]));
    chk("fs0", 32'(fs0), 32'(efs));
    chk("ls0", 32'(ls0), 32'(els));
    chk("x1", 32'(x1), ex);
    chk("y1", 32'(y1), ey);
    chk("blank1", 32'(blank1), 32'(e1[2]));
    chk("hs1", 32'(hs1), 32'(e1[1]));
    chk("vs1", 32'(vs1), 32'(e1[0]));
    chk("fs1", 32'(fs1), 32'(efs));
    chk("ls1", 32'(ls1), 32'(els));
  endtask

  task automatic track();
    if (pix_en && reset_n) begin
      en_cyc++;
      if (fs0) begin
        if (last_fs >= 0) begin
          chk("fs_period", en_cyc - last_fs, HT * VT);
          chk("ls_per_frame", ls_cnt, VA);
        end
        last_fs = en_cyc;
        ls_cnt  = 0;
      end
      if (ls0) begin
        ls_cnt++;
        last_ls = en_cyc;
      end
      if (!hs0 && prev_hs) begin
        hs_fall = en_cyc;
        if (last_ls >= 0 && en_cyc - last_ls < HT)
          chk("hs_offset", en_cyc - last_ls, HA + HF + 1);
      end
      if (hs0 && !prev_hs && hs_fall >= 0) chk("hs_width", en_cyc - hs_fall, HSW);
      if (!vs0 && prev_vs) begin
        vs_fall = en_cyc;
        if (last_fs >= 0) chk("vs_offset", en_cyc - last_fs, (VA + VF) * HT + 1);
      end
      if (vs0 && !prev_vs && vs_fall >= 0) chk("vs_width", en_cyc - vs_fall, VSW * HT);
      prev_hs = hs0;
      prev_vs = vs0;
    end
  endtask

  // One clock cycle: drive enable, compare at the falling edge, then
  // advance the reference on the rising edge if the DUT should advance.
  task automatic step(input logic en);
    pix_en = en;
    @(negedge clk);
    check_outputs();
    track();
    @(posedge clk);
    if (en && reset_n) advance_model();
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    pix_en  = 1'b0;
    model_reset();

    // Held in reset, with and without enable: nothing moves, pulses stay 0.
    step(1'b0);
    step(1'b1);
    step(1'b1);
    reset_n = 1'b1;

    // First frame from release, back to (0,0).
    repeat (HT * VT) step(1'b1);

    // Move to the last visible pixel of the frame, then pause.
    for (int i = 0; i < HT * VT && !(mh == HA - 1 && mv == VA - 1); i++) step(1'b1);
    chk("pause_x", 32'(x0), HA - 1);
    chk("pause_y", 32'(y0), VA - 1);
    repeat (5) step(1'b0);
    repeat (4) step(1'b1);

    // Corner wrap (HT-1, VT-1) -> (0,0).
    for (int i = 0; i < HT * VT && !(mh == HT - 1 && mv == VT - 1); i++) step(1'b1);
    step(1'b1);
    chk("wrap_fs", 32'(fs0), 1);
    chk("wrap_ls", 32'(ls0), 1);
    chk("wrap_x", 32'(x0), 0);
    chk("wrap_y", 32'(y0), 0);
    repeat (HT + 3) step(1'b1);

    // Mid-frame asynchronous reset at the centre of the active area.
    for (int i = 0; i < HT * VT && !(mh == HA / 2 && mv == VA / 2); i++) step(1'b1);
    repeat (4) step(1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_blank0", 32'(blank0), 0);
    chk("rst_hs0", 32'(hs0), 1);
    chk("rst_vs0", 32'(vs0), 1);
    chk("rst_x0", 32'(x0), 0);
    chk("rst_y0", 32'(y0), 0);
    chk("rst_fs0", 32'(fs0), 0);
    chk("rst_blank1", 32'(blank1), 0);
    chk("rst_hs1", 32'(hs1), 1);
    chk("rst_ls1", 32'(ls1), 0);
    model_reset();
    repeat (3) step(1'b1);
    reset_n = 1'b1;
    repeat (3 * HT) step(1'b1);

    // Irregular enable over more than a frame.
    repeat (1500) step(logic'($urandom_range(0, 3) != 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
